vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the team's 640x480 VGA timing generator.
- Samples H_SYNC, V_SYNC and 8-bit RGB (3-3-2) at the 50 MHz system clock, recovers the 25 MHz pixel phase and pixel/line counters, and locks to the incoming timing.
- Emits active-area pixels with x/y coordinates.
- Used as an on-chip loopback checker and frame-capture front end for the Pong design and its testbenches.

Parameters:
- H_CLOCKS, 800, pixel ticks per line
- H_PULSEW_CLOCKS, 96, HSYNC low width in ticks
- H_FRONTP_CLOCKS, 16, ticks from HSYNC rise to first active pixel
- H_DISP_CLOCKS, 640, active pixels per line
- V_LINES, 521, lines per frame
- V_PULSEW_LINES, 2, VSYNC low width in lines
- V_FRONTP_LINES, 10, lines from VSYNC rise to first active line
- V_DISP_LINES, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
- CLK_IN  in  1  50 MHz system clock
- RST_N  in  1  asynchronous active-low reset
- H_SYNC  in  1  active-low horizontal sync
- V_SYNC  in  1  active-low vertical sync
- RGB_in  in  8  pixel colour {R[2:0],G[2:0],B[1:0]}
- PIX_VALID  out  1  active pixel on PIX_RGB/X_OUT/Y_OUT this cycle (only when locked)
- PIX_RGB  out  8  captured pixel colour
- X_OUT  out  10  active column 0..639
- Y_OUT  out  10  active row 0..479
- FRAME_START  out  1  one-cycle pulse on the VSYNC falling edge while locked
- LOCKED  out  1  timing locked
- SYNC_ERR  out  1  one-cycle pulse on any line- or frame-length violation in ACQUIRE/LOCKED

Behaviour:
- Reset (RST_N low, asynchronous): all counters, pipeline flops and outputs go to 0; FSM enters SEARCH; sync-pipeline flops reset to 1 (idle-high syncs).
- Input pipeline: H_SYNC, V_SYNC and RGB_in each pass through 2 flops (s1, s2); s3 holds the previous s2.
  - hfall = s3_h & ~s2_h; vfall = s3_v & ~s2_v.
- Pixel phase: 1-bit phase toggles every cycle; hfall forces phase to 0.
  - tick = (phase == 0) | hfall. This gives one tick every 2 CLK_IN cycles, aligned to HSYNC.
- H_CNT (10 b): on hfall -> 0; else on tick -> H_CNT+1, saturating at 1023.
- V_CNT (10 b): on vfall -> 0, including when hfall occurs in the same cycle (the generator drops both syncs together); else on hfall -> V_CNT+1, saturating at 1023.
- Line check (ACQUIRE/LOCKED):
  - hfall with H_CNT != H_CLOCKS-1 is an error.
  - H_CNT reaching H_CLOCKS with no hfall (timeout) is an error.
- Frame check (ACQUIRE/LOCKED):
  - vfall with V_CNT != V_LINES-1 is an error.
  - V_CNT reaching V_LINES with no vfall is an error.
- Any error: SYNC_ERR pulses for 1 cycle and the FSM returns to SEARCH.
- FSM states:
  - SEARCH: counters run, no checks. On vfall -> ACQUIRE, good_frames=0.
  - ACQUIRE: on each error-free vfall, good_frames++. When good_frames == LOCK_FRAMES -> LOCKED, and LOCKED rises the cycle after that vfall.
  - LOCKED: stays while error-free. On error -> SEARCH, and LOCKED falls the cycle after the error.
- Active window:
  - H_CNT in [H_PULSEW_CLOCKS+H_FRONTP_CLOCKS, +H_DISP_CLOCKS) = [112,752).
  - V_CNT in [V_PULSEW_LINES+V_FRONTP_LINES, +V_DISP_LINES) = [12,492).
- Output stage (registered): when tick & window & LOCKED:
  - PIX_VALID=1, PIX_RGB=s2_rgb, X_OUT=H_CNT-112, Y_OUT=V_CNT-12.
  - Otherwise PIX_VALID=0 and X_OUT/Y_OUT/PIX_RGB hold their last values.
- Latency: PIX_RGB equals RGB_in sampled 3 CLK_IN cycles earlier. PIX_VALID is high for exactly 640 cycles per active line, every other cycle.
- FRAME_START: registered pulse, 1 cycle after vfall is seen, only if LOCKED is 1 or becomes 1 on that vfall.
- All arithmetic is unsigned 10 bit. Window comparisons use the unsaturated ranges; saturation only prevents wrap-around producing false windows.

Decomposition:
- Shared package vga_timing_pkg: the 640x480 constants (H_*, V_*), derived H_ACT_START=112, V_ACT_START=12, and the FSM state enum {SEARCH, ACQUIRE, LOCKED}. The timing generator is migrated to the same package.
- One natural sub-module: vga_sync_edge. It holds the 2-flop synchronizer, s3 and the fall detection for one sync line, instantiated twice. Counters, FSM and output stage stay in vga_sync_decoder.

Test Plan:
- Loopback from the existing timing generator, RGB_in = 8'hE3 constant:
  - LOCKED rises 1 cycle after the 2nd checked VSYNC fall (3rd fall overall).
  - Afterwards exactly 640x480 PIX_VALID pulses per frame, all PIX_RGB=E3.
  - First valid pixel has X=0,Y=0; last has X=639,Y=479.
- Generator RGB_in = {x[7:0]} pattern:
  - Every valid pixel has PIX_RGB == X_OUT[7:0], delayed 3 cycles from the input.
  - FRAME_START fires once per 833,600 cycles.
- Inject a 799-tick line while LOCKED:
  - SYNC_ERR pulses once at that hfall and LOCKED falls next cycle.
  - Relock occurs after 2 further good frames.
- Hold H_SYNC high indefinitely while LOCKED:
  - Timeout SYNC_ERR fires when H_CNT reaches 800 (1600 cycles after the last hfall).
  - No PIX_VALID afterwards.
- Frame of 520 lines in ACQUIRE: SYNC_ERR, back to SEARCH, good_frames cleared, LOCKED stays 0.
- Assert RST_N low mid-line while LOCKED:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, lock is regained only after the full SEARCH/ACQUIRE sequence.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480 VGA timing constants for the timing generator and the
// receive-side sync decoder, plus the decoder's lock FSM state type and a
// saturating 10-bit increment used by its pixel/line counters.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int H_CLOCKS        = 800;  // pixel ticks per line
  localparam int H_PULSEW_CLOCKS = 96;   // HSYNC low width
  localparam int H_FRONTP_CLOCKS = 16;   // HSYNC rise to first active pixel
  localparam int H_DISP_CLOCKS   = 640;  // active pixels per line

  localparam int V_LINES         = 521;  // lines per frame
  localparam int V_PULSEW_LINES  = 2;    // VSYNC low width
  localparam int V_FRONTP_LINES  = 10;   // VSYNC rise to first active line
  localparam int V_DISP_LINES    = 480;  // active lines per frame

  localparam int LOCK_FRAMES     = 2;    // consecutive good frames to lock

  localparam int H_ACT_START = H_PULSEW_CLOCKS + H_FRONTP_CLOCKS;  // 112
  localparam int V_ACT_START = V_PULSEW_LINES + V_FRONTP_LINES;    // 12

  // ST_ prefix keeps the state names clear of the decoder's LOCKED port.
  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ACQUIRE,
    ST_LOCKED
  } sync_state_e;

  // Counters stick at all-ones so a missing sync can never wrap back into
  // the active window.
  function automatic logic [9:0] sat_inc(input logic [9:0] value);
    return (value == 10'h3FF) ? value : value + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// ---------------------------------------------------------------------------
// vga_sync_edge
// Two-flop synchronizer for one active-low sync line, a third flop holding
// the previous synchronized level, and falling-edge detection.
//   CLK_IN    : system clock
//   RST_N     : asynchronous active-low reset (flops reset to idle-high)
//   sync_line : raw asynchronous sync input
//   fall      : high for one cycle when the synchronized level goes 1 -> 0
// ---------------------------------------------------------------------------
module vga_sync_edge (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic sync_line,
  output logic fall
);

  logic s1, s2, s3;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      // Idle level of an active-low sync is high; resetting to 1 prevents a
      // false falling edge straight out of reset.
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= sync_line;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;

endmodule

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
// Receive-side counterpart of the 640x480 VGA timing generator. Samples the
// syncs and 3-3-2 RGB at the 50 MHz system clock, recovers the 25 MHz pixel
// phase and pixel/line counters, locks after LOCK_FRAMES good frames and
// emits active-area pixels with coordinates.
//   CLK_IN      : 50 MHz system clock
//   RST_N       : asynchronous active-low reset
//   H_SYNC      : active-low horizontal sync
//   V_SYNC      : active-low vertical sync
//   RGB_in      : pixel colour {R[2:0],G[2:0],B[1:0]}
//   PIX_VALID   : active pixel on PIX_RGB/X_OUT/Y_OUT (only while locked)
//   PIX_RGB     : captured pixel colour
//   X_OUT/Y_OUT : active column / row
//   FRAME_START : one-cycle pulse after a VSYNC fall while locked
//   LOCKED      : timing locked
//   SYNC_ERR    : one-cycle pulse on a line/frame length violation
// ---------------------------------------------------------------------------
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_CLOCKS        = vga_timing_pkg::H_CLOCKS,
  parameter int H_PULSEW_CLOCKS = vga_timing_pkg::H_PULSEW_CLOCKS,
  parameter int H_FRONTP_CLOCKS = vga_timing_pkg::H_FRONTP_CLOCKS,
  parameter int H_DISP_CLOCKS   = vga_timing_pkg::H_DISP_CLOCKS,
  parameter int V_LINES         = vga_timing_pkg::V_LINES,
  parameter int V_PULSEW_LINES  = vga_timing_pkg::V_PULSEW_LINES,
  parameter int V_FRONTP_LINES  = vga_timing_pkg::V_FRONTP_LINES,
  parameter int V_DISP_LINES    = vga_timing_pkg::V_DISP_LINES,
  parameter int LOCK_FRAMES     = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  input  logic       H_SYNC,
  input  logic       V_SYNC,
  input  logic [7:0] RGB_in,
  output logic       PIX_VALID,
  output logic [7:0] PIX_RGB,
  output logic [9:0] X_OUT,
  output logic [9:0] Y_OUT,
  output logic       FRAME_START,
  output logic       LOCKED,
  output logic       SYNC_ERR
);

  localparam logic [9:0] H_LAST   = 10'(H_CLOCKS - 1);
  localparam logic [9:0] V_LAST   = 10'(V_LINES - 1);
  localparam logic [9:0] H_ACT_LO = 10'(H_PULSEW_CLOCKS + H_FRONTP_CLOCKS);
  localparam logic [9:0] H_ACT_HI = 10'(H_PULSEW_CLOCKS + H_FRONTP_CLOCKS + H_DISP_CLOCKS);
  localparam logic [9:0] V_ACT_LO = 10'(V_PULSEW_LINES + V_FRONTP_LINES);
  localparam logic [9:0] V_ACT_HI = 10'(V_PULSEW_LINES + V_FRONTP_LINES + V_DISP_LINES);
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_FRAMES);

  logic        h_fall, v_fall;
  logic [7:0]  rgb_s1, rgb_s2;
  logic        phase, tick;
  logic [9:0]  h_cnt, v_cnt, h_next, v_next;
  logic        h_err, v_err, err, h_win, v_win, pix_fire;
  logic [3:0]  good_frames, good_frames_next;
  sync_state_e state, state_next;

  vga_sync_edge u_h_edge (.CLK_IN(CLK_IN), .RST_N(RST_N), .sync_line(H_SYNC), .fall(h_fall));
  vga_sync_edge u_v_edge (.CLK_IN(CLK_IN), .RST_N(RST_N), .sync_line(V_SYNC), .fall(v_fall));

  // The hfall cycle is itself phase 0 (a tick), so ticks land every second
  // cycle starting exactly at the HSYNC edge.
  assign tick = ~phase | h_fall;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    h_next = h_cnt;
    if (h_fall)    h_next = '0;
    else if (tick) h_next = sat_inc(h_cnt);

    v_next = v_cnt;
    if (v_fall)      v_next = '0;   // wins over a simultaneous hfall
    else if (h_fall) v_next = sat_inc(v_cnt);
  end

  // Length checks: wrong count at the sync edge, or the count running past
  // the period without one.
  assign h_err = (h_fall && h_cnt != H_LAST) || (tick && !h_fall && h_cnt == H_LAST);
  assign v_err = (v_fall && v_cnt != V_LAST) || (h_fall && !v_fall && v_cnt == V_LAST);
  assign err   = (state != ST_SEARCH) && (h_err || v_err);

  always_comb begin
    state_next       = state;
    good_frames_next = good_frames;
    unique case (state)
      ST_SEARCH: begin
        if (v_fall) begin
          state_next       = ST_ACQUIRE;
          good_frames_next = '0;
        end
      end
      ST_ACQUIRE: begin
        if (err) begin
          state_next       = ST_SEARCH;
          good_frames_next = '0;
        end else if (v_fall) begin
          good_frames_next = good_frames + 4'd1;
          if (good_frames + 4'd1 == LOCK_TARGET) state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (err) state_next = ST_SEARCH;
      end
      default: state_next = ST_SEARCH;
    endcase
  end

  // Window is judged on the count this tick assigns, which is the pixel
  // whose colour sits in rgb_s2 now: coordinate and colour stay paired.
  assign h_win    = (h_next >= H_ACT_LO) && (h_next < H_ACT_HI);
  assign v_win    = (v_next >= V_ACT_LO) && (v_next < V_ACT_HI);
  assign pix_fire = tick && h_win && v_win && LOCKED;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      rgb_s1      <= '0;
      rgb_s2      <= '0;
      phase       <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      state       <= ST_SEARCH;
      good_frames <= '0;
      PIX_VALID   <= 1'b0;
      PIX_RGB     <= '0;
      X_OUT       <= '0;
      Y_OUT       <= '0;
      FRAME_START <= 1'b0;
      LOCKED      <= 1'b0;
      SYNC_ERR    <= 1'b0;
    end else begin
      rgb_s1      <= RGB_in;
      rgb_s2      <= rgb_s1;
      phase       <= h_fall ? 1'b1 : ~phase;
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      state       <= state_next;
      good_frames <= good_frames_next;
      PIX_VALID   <= pix_fire;
      if (pix_fire) begin
        PIX_RGB <= rgb_s2;
        X_OUT   <= h_next - H_ACT_LO;
        Y_OUT   <= v_next - V_ACT_LO;
      end
      FRAME_START <= v_fall && (state_next == ST_LOCKED);
      LOCKED      <= (state_next == ST_LOCKED);
      SYNC_ERR    <= err;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
// Drives the decoder with a scaled-down VGA raster (small parameters keep
// whole frames short) carrying random pixel colours. A raster-order queue of
// expected {x, y, rgb} is filled as pixels are generated and drained as
// PIX_VALID pulses arrive; event cycles for lock, errors and frame starts
// are compared with values derived from the sync drive times.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int TH   = 24;  // ticks per line
  localparam int HPW  = 4;
  localparam int HFP  = 3;
  localparam int HD   = 12;
  localparam int TV   = 14;  // lines per frame
  localparam int VPW  = 2;
  localparam int VFP  = 2;
  localparam int VD   = 6;
  localparam int HACT = HPW + HFP;
  localparam int VACT = VPW + VFP;
  localparam int FRAME_PIX = HD * VD;
  localparam int LAT  = 3;   // sync drive -> registered output reaction

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       h_sync = 1'b1, v_sync = 1'b1;
  logic [7:0] rgb = '0;
  logic       pix_valid, frame_start, locked, sync_err;
  logic [7:0] pix_rgb;
  logic [9:0] x_out, y_out;

  vga_sync_decoder #(
    .H_CLOCKS(TH), .H_PULSEW_CLOCKS(HPW), .H_FRONTP_CLOCKS(HFP), .H_DISP_CLOCKS(HD),
    .V_LINES(TV), .V_PULSEW_LINES(VPW), .V_FRONTP_LINES(VFP), .V_DISP_LINES(VD),
    .LOCK_FRAMES(2)
  ) dut (
    .CLK_IN(clk), .RST_N(rst_n), .H_SYNC(h_sync), .V_SYNC(v_sync), .RGB_in(rgb),
    .PIX_VALID(pix_valid), .PIX_RGB(pix_rgb), .X_OUT(x_out), .Y_OUT(y_out),
    .FRAME_START(frame_start), .LOCKED(locked), .SYNC_ERR(sync_err)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [27:0] exp_q[$];
  int valid_cnt = 0, err_cnt = 0, fs_cnt = 0, rise_cnt = 0;
  int err_cyc = -1, fs_cyc = -1, rise_cyc = -1, fall_cyc = -1;
  logic prev_locked = 1'b0, prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (locked && !prev_locked) begin rise_cnt++; rise_cyc = cyc; end
      if (!locked && prev_locked) fall_cyc = cyc;
      if (sync_err)    begin err_cnt++; err_cyc = cyc; end
      if (frame_start) begin fs_cnt++;  fs_cyc  = cyc; end
      if (pix_valid) begin
        valid_cnt++;
        check("pix_gap", 32'(prev_valid), 32'd0);
        check("pix_expected", 32'(exp_q.size() == 0), 32'd0);
        if (exp_q.size() != 0) check("pixel", 32'({x_out, y_out, pix_rgb}), 32'(exp_q.pop_front()));
      end
      prev_locked = locked;
      prev_valid  = pix_valid;
    end else begin
      prev_locked = 1'b0;
      prev_valid  = 1'b0;
    end
  end

  // ---------------- raster generator ----------------
  int frame_cyc, after_short_cyc;

  // Emits one frame of `lines` lines; line `short_line` is one tick short.
  // Stops after `cut` pixels when cut > 0. Pixels are queued as expected
  // output only if the decoder should be locked while they pass.
  task automatic gen_frame(input int lines, input int short_line, input int cut, input bit exp_lock);
    int n = 0;
    frame_cyc = cyc;
    for (int v = 0; v < lines; v++) begin
      int len = (v == short_line) ? TH - 1 : TH;
      if (short_line >= 0 && v == short_line + 1) after_short_cyc = cyc;
      for (int h = 0; h < len; h++) begin
        if (cut > 0 && n == cut) return;
        h_sync = (h < HPW) ? 1'b0 : 1'b1;
        v_sync = (v < VPW) ? 1'b0 : 1'b1;
        rgb    = 8'($urandom);
        if (exp_lock && (short_line < 0 || v <= short_line) &&
            h >= HACT && h < HACT + HD && v >= VACT && v < VACT + VD)
          exp_q.push_back({10'(h - HACT), 10'(v - VACT), rgb});
        n++;
        repeat (2) @(negedge clk);
      end
    end
  endtask

  int v0, e0, f0, r0, f2;

  initial begin
    // ---- reset ----
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst PIX_VALID", 32'(pix_valid), 0);
    check("rst PIX_RGB", 32'(pix_rgb), 0);
    check("rst X_OUT", 32'(x_out), 0);
    check("rst Y_OUT", 32'(y_out), 0);
    check("rst FRAME_START", 32'(frame_start), 0);
    check("rst LOCKED", 32'(locked), 0);
    check("rst SYNC_ERR", 32'(sync_err), 0);
    rst_n = 1'b1;

    // ---- acquire: falls 1 and 2 do not lock ----
    gen_frame(TV, -1, 0, 1'b0);
    gen_frame(TV, -1, 0, 1'b0);
    check("acq LOCKED", 32'(locked), 0);
    check("acq valid", 32'(valid_cnt), 0);

    // ---- third fall locks; full frame of pixels ----
    v0 = valid_cnt; f0 = fs_cnt;
    gen_frame(TV, -1, 0, 1'b1);
    f2 = frame_cyc;
    check("lock rise cyc", 32'(rise_cyc), 32'(f2 + LAT));
    check("lock fs cyc", 32'(fs_cyc), 32'(f2 + LAT));
    check("f2 valid cnt", 32'(valid_cnt - v0), FRAME_PIX);
    check("f2 queue empty", 32'(exp_q.size()), 0);
    v0 = valid_cnt;
    gen_frame(TV, -1, 0, 1'b1);
    check("f3 valid cnt", 32'(valid_cnt - v0), FRAME_PIX);
    check("f3 fs cyc", 32'(fs_cyc), 32'(frame_cyc + LAT));
    check("fs count", 32'(fs_cnt - f0), 2);

    // ---- short line while locked ----
    v0 = valid_cnt; e0 = err_cnt;
    gen_frame(TV, 5, 0, 1'b1);
    check("short err cnt", 32'(err_cnt - e0), 1);
    check("short err cyc", 32'(err_cyc), 32'(after_short_cyc + LAT));
    check("short lock fall", 32'(fall_cyc), 32'(after_short_cyc + LAT));
    check("short valid cnt", 32'(valid_cnt - v0), 2 * HD);
    check("short queue empty", 32'(exp_q.size()), 0);

    // ---- relock after two further good frames ----
    gen_frame(TV, -1, 0, 1'b0);
    gen_frame(TV, -1, 0, 1'b0);
    check("relock not yet", 32'(locked), 0);
    v0 = valid_cnt;
    gen_frame(TV, -1, 0, 1'b1);
    check("relock rise cyc", 32'(rise_cyc), 32'(frame_cyc + LAT));
    check("relock valid cnt", 32'(valid_cnt - v0), FRAME_PIX);

    // ---- HSYNC stuck high while locked: timeout ----
    v0 = valid_cnt; e0 = err_cnt;
    gen_frame(TV, -1, HPW + 2, 1'b1);
    h_sync = 1'b1; v_sync = 1'b1;
    repeat (2 * TH + 20) @(negedge clk);
    check("timeout err cnt", 32'(err_cnt - e0), 1);
    check("timeout err cyc", 32'(err_cyc), 32'(frame_cyc + LAT + 2 * TH));
    check("timeout lock fall", 32'(fall_cyc), 32'(frame_cyc + LAT + 2 * TH));
    check("timeout no valid", 32'(valid_cnt - v0), 0);

    // ---- relock, then async reset mid active line ----
    gen_frame(TV, -1, 0, 1'b0);
    gen_frame(TV, -1, 0, 1'b0);
    gen_frame(TV, -1, 0, 1'b1);
    check("relock2 rise cyc", 32'(rise_cyc), 32'(frame_cyc + LAT));
    gen_frame(TV, -1, 5 * TH + HACT + 5, 1'b1);
    @(posedge clk);
    check("pre-reset LOCKED", 32'(locked), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async PIX_VALID", 32'(pix_valid), 0);
    check("async PIX_RGB", 32'(pix_rgb), 0);
    check("async X_OUT", 32'(x_out), 0);
    check("async Y_OUT", 32'(y_out), 0);
    check("async FRAME_START", 32'(frame_start), 0);
    check("async LOCKED", 32'(locked), 0);
    check("async SYNC_ERR", 32'(sync_err), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ---- short frame while acquiring: error, no lock ----
    r0 = rise_cnt; e0 = err_cnt;
    gen_frame(TV, -1, 0, 1'b0);
    gen_frame(TV - 1, -1, 0, 1'b0);
    gen_frame(TV, -1, 0, 1'b0);
    check("acq err cnt", 32'(err_cnt - e0), 1);
    check("acq err cyc", 32'(err_cyc), 32'(frame_cyc + LAT));
    check("acq no lock", 32'(rise_cnt - r0), 0);
    gen_frame(TV, -1, 0, 1'b0);
    gen_frame(TV, -1, 0, 1'b0);
    check("acq still unlocked", 32'(locked), 0);
    v0 = valid_cnt;
    gen_frame(TV, -1, 0, 1'b1);
    check("final rise cyc", 32'(rise_cyc), 32'(frame_cyc + LAT));
    check("final valid cnt", 32'(valid_cnt - v0), FRAME_PIX);
    check("final queue empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
